// File: rtl/sha3_pkg.sv
// rtl/sha3_pkg.sv - shared constants and FSM encoding for the SHA-3 sequencer
package sha3_pkg;

  localparam int ROUNDS     = 24;
  localparam int RATE_WORDS = 18;
  localparam int RIDX_W     = 5;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BLK,
    ABSORB,
    ROUND,
    DONE
  } seq_state_e;

endpackage

// File: rtl/sha3_byte_packer.sv
// rtl/sha3_byte_packer.sv - packs message bytes into padder words and tracks the message tail
module sha3_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        byte_last,
  output logic        byte_ready,
  output logic [31:0] pad_in,
  output logic        pad_in_ready,
  output logic        pad_is_last,
  output logic [1:0]  pad_byte_num,
  input  logic        pad_buffer_full,
  input  logic        done,
  input  logic        clr,
  input  logic        capture,
  output logic        block_final
);

  logic [31:0] lanes_q;
  logic [31:0] merged;
  logic [31:0] word_q;
  logic [1:0]  cnt_q;
  logic [1:0]  byte_num_q;
  logic        word_pend_q;
  logic        is_last_q;
  logic        tail_owed_q;
  logic        last_sent_q;
  logic        block_final_q;
  logic        armed_q;
  logic        byte_fire;
  logic        word_fire;

  // armed_q keeps byte_ready low while reset is held and for the first cycle after
  assign byte_ready   = armed_q & ~word_pend_q & ~last_sent_q & ~done;
  assign byte_fire    = byte_valid & byte_ready;
  assign word_fire    = word_pend_q & ~pad_buffer_full;
  assign pad_in       = word_q;
  assign pad_in_ready = word_pend_q;
  assign pad_is_last  = is_last_q;
  assign pad_byte_num = byte_num_q;
  assign block_final  = block_final_q;

  always_comb begin
    merged = lanes_q;
    case (cnt_q)
      2'd0:    merged[31:24] = byte_in;
      2'd1:    merged[23:16] = byte_in;
      2'd2:    merged[15:8]  = byte_in;
      default: merged[7:0]   = byte_in;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lanes_q       <= '0;
      word_q        <= '0;
      cnt_q         <= '0;
      byte_num_q    <= '0;
      word_pend_q   <= 1'b0;
      is_last_q     <= 1'b0;
      tail_owed_q   <= 1'b0;
      last_sent_q   <= 1'b0;
      block_final_q <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      if (clr) begin
        lanes_q       <= '0;
        word_q        <= '0;
        cnt_q         <= '0;
        byte_num_q    <= '0;
        word_pend_q   <= 1'b0;
        is_last_q     <= 1'b0;
        tail_owed_q   <= 1'b0;
        last_sent_q   <= 1'b0;
        block_final_q <= 1'b0;
      end else begin
        if (word_fire) begin
          if (tail_owed_q) begin
            word_q      <= '0;
            is_last_q   <= 1'b1;
            byte_num_q  <= 2'd0;
            tail_owed_q <= 1'b0;
          end else begin
            word_q      <= '0;
            word_pend_q <= 1'b0;
            is_last_q   <= 1'b0;
            byte_num_q  <= 2'd0;
          end
          if (is_last_q)
            last_sent_q <= 1'b1;
        end
        if (byte_fire) begin
          if (cnt_q == 2'd3 || byte_last) begin
            word_q      <= merged;
            word_pend_q <= 1'b1;
            lanes_q     <= '0;
            cnt_q       <= 2'd0;
            is_last_q   <= byte_last & (cnt_q != 2'd3);
            // a full word wraps to 0, matching the empty tail that follows it
            byte_num_q  <= cnt_q + 2'd1;
            tail_owed_q <= byte_last & (cnt_q == 2'd3);
          end else begin
            lanes_q <= merged;
            cnt_q   <= cnt_q + 2'd1;
          end
        end
        if (word_fire && is_last_q)
          block_final_q <= 1'b1;
        else if (capture)
          block_final_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sha3_sequencer.sv
// rtl/sha3_sequencer.sv - block/round sequencer between the byte stream, padder and Keccak rounds
module sha3_sequencer #(
  parameter int ROUNDS = sha3_pkg::ROUNDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        byte_last,
  output logic        byte_ready,
  output logic [31:0] pad_in,
  output logic        pad_in_ready,
  output logic        pad_is_last,
  output logic [1:0]  pad_byte_num,
  input  logic        pad_buffer_full,
  input  logic        pad_out_ready,
  output logic        pad_f_ack,
  output logic        pad_clr,
  output logic        absorb,
  output logic        round_en,
  output logic [4:0]  round_idx,
  output logic        perm_busy,
  output logic        hash_valid,
  input  logic        hash_ack
);

  import sha3_pkg::*;

  localparam logic [RIDX_W-1:0] LAST_ROUND = RIDX_W'(ROUNDS - 1);

  seq_state_e        state_q, state_d;
  logic [RIDX_W-1:0] ridx_q, ridx_d;
  logic              final_q, final_d;
  logic              pad_clr_q;
  logic              capture;
  logic              done_ack;
  logic              block_final;

  sha3_byte_packer u_packer (
    .clk             (clk),
    .reset           (reset),
    .byte_in         (byte_in),
    .byte_valid      (byte_valid),
    .byte_last       (byte_last),
    .byte_ready      (byte_ready),
    .pad_in          (pad_in),
    .pad_in_ready    (pad_in_ready),
    .pad_is_last     (pad_is_last),
    .pad_byte_num    (pad_byte_num),
    .pad_buffer_full (pad_buffer_full),
    .done            (state_q == DONE),
    .clr             (done_ack),
    .capture         (capture),
    .block_final     (block_final)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ridx_q    <= '0;
      final_q   <= 1'b0;
      pad_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ridx_q    <= ridx_d;
      final_q   <= final_d;
      pad_clr_q <= done_ack;
    end
  end

  always_comb begin
    state_d  = state_q;
    ridx_d   = ridx_q;
    final_d  = final_q;
    capture  = 1'b0;
    done_ack = 1'b0;
    case (state_q)
      IDLE:
        if (byte_valid && byte_ready)
          state_d = WAIT_BLK;
      WAIT_BLK:
        if (pad_out_ready) begin
          state_d = ABSORB;
          final_d = block_final;
          capture = 1'b1;
        end
      ABSORB: begin
        state_d = ROUND;
        ridx_d  = '0;
      end
      ROUND:
        // the counter parks at 0 on exit rather than wrapping past the last round
        if (ridx_q == LAST_ROUND) begin
          state_d = final_q ? DONE : WAIT_BLK;
          ridx_d  = '0;
        end else begin
          ridx_d = ridx_q + 1'b1;
        end
      DONE:
        if (hash_ack) begin
          state_d  = IDLE;
          done_ack = 1'b1;
        end
      default:
        state_d = IDLE;
    endcase
  end

  assign absorb     = (state_q == ABSORB);
  assign pad_f_ack  = (state_q == ABSORB);
  assign round_en   = (state_q == ROUND);
  assign perm_busy  = (state_q == ROUND);
  assign hash_valid = (state_q == DONE);
  assign round_idx  = ridx_q;
  assign pad_clr    = pad_clr_q;

endmodule

// File: tb/tb_sha3_sequencer.sv
// tb/tb_sha3_sequencer.sv - self-checking bench for sha3_sequencer with a behavioural padder
module tb_sha3_sequencer;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_last;
  logic        byte_ready;
  logic [31:0] pad_in;
  logic        pad_in_ready;
  logic        pad_is_last;
  logic [1:0]  pad_byte_num;
  logic        pad_buffer_full;
  logic        pad_out_ready = 1'b0;
  logic        pad_f_ack;
  logic        pad_clr;
  logic        absorb;
  logic        round_en;
  logic [4:0]  round_idx;
  logic        perm_busy;
  logic        hash_valid;
  logic        hash_ack;

  int checks = 0;
  int errors = 0;

  logic        model_full = 1'b0;
  logic        force_full = 1'b0;
  logic        nx_full = 1'b0;
  logic        nx_ready = 1'b0;
  logic        hv_prev = 1'b0;
  logic        prev_absorb = 1'b0;
  logic [34:0] e;
  logic [34:0] exp_q[$];
  int          pwords = 0;
  int          rcount = 0;
  int          cyc = 0;
  int          last_r23 = -10;
  int          n_round = 0;
  int          n_absorb = 0;
  int          n_clr = 0;
  logic [47:0] outs;

  assign pad_buffer_full = model_full | force_full;
  assign outs = {byte_ready, pad_in, pad_in_ready, pad_is_last, pad_byte_num, pad_f_ack,
                 pad_clr, absorb, round_en, round_idx, perm_busy, hash_valid};

  sha3_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .byte_in         (byte_in),
    .byte_valid      (byte_valid),
    .byte_last       (byte_last),
    .byte_ready      (byte_ready),
    .pad_in          (pad_in),
    .pad_in_ready    (pad_in_ready),
    .pad_is_last     (pad_is_last),
    .pad_byte_num    (pad_byte_num),
    .pad_buffer_full (pad_buffer_full),
    .pad_out_ready   (pad_out_ready),
    .pad_f_ack       (pad_f_ack),
    .pad_clr         (pad_clr),
    .absorb          (absorb),
    .round_en        (round_en),
    .round_idx       (round_idx),
    .perm_busy       (perm_busy),
    .hash_valid      (hash_valid),
    .hash_ack        (hash_ack)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      nx_full = 1'b0;
      nx_ready = 1'b0;
      pwords = 0;
      rcount = 0;
      hv_prev = 1'b0;
      prev_absorb = 1'b0;
      exp_q.delete();
    end else begin
      cyc++;
      if (pad_f_ack === 1'b1 || pad_clr === 1'b1) begin
        nx_full = 1'b0;
        nx_ready = 1'b0;
        pwords = 0;
      end
      if (pad_in_ready === 1'b1 && pad_buffer_full === 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $error("FAIL word_expected observed=0 expected=1");
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checks++;
          if (pad_in !== e[31:0]) begin
            errors++;
            $error("FAIL word_data observed=%0h expected=%0h", pad_in, e[31:0]);
          end
          checks++;
          if (pad_is_last !== e[34]) begin
            errors++;
            $error("FAIL word_last observed=%0h expected=%0h", pad_is_last, e[34]);
          end
          checks++;
          if (pad_byte_num !== e[33:32]) begin
            errors++;
            $error("FAIL word_bnum observed=%0h expected=%0h", pad_byte_num, e[33:32]);
          end
        end
        pwords++;
        if (pwords == 18 || pad_is_last === 1'b1) begin
          nx_full = 1'b1;
          nx_ready = 1'b1;
        end
      end
      if (absorb === 1'b1) begin
        n_absorb++;
        rcount = 0;
        checks++;
        if (pad_f_ack !== 1'b1) begin
          errors++;
          $error("FAIL absorb_ack observed=%0h expected=1", pad_f_ack);
        end
      end
      if (round_en === 1'b1) begin
        checks++;
        if (round_idx !== 5'(rcount)) begin
          errors++;
          $error("FAIL round_idx observed=%0h expected=%0h", round_idx, 5'(rcount));
        end
        checks++;
        if (perm_busy !== 1'b1) begin
          errors++;
          $error("FAIL perm_busy observed=%0h expected=1", perm_busy);
        end
        if (rcount == 0) begin
          checks++;
          if (prev_absorb !== 1'b1) begin
            errors++;
            $error("FAIL absorb_to_round observed=%0h expected=1", prev_absorb);
          end
        end
        if (round_idx === 5'd23) last_r23 = cyc;
        rcount++;
        n_round++;
      end
      if (hash_valid === 1'b1 && hv_prev !== 1'b1) begin
        checks++;
        if (cyc != last_r23 + 1) begin
          errors++;
          $error("FAIL digest_latency observed=%0d expected=%0d", cyc, last_r23 + 1);
        end
      end
      if (pad_clr === 1'b1) n_clr++;
      hv_prev = hash_valid;
      prev_absorb = absorb;
    end
  end

  always @(posedge clk) begin
    #1;
    model_full = nx_full;
    pad_out_ready = nx_ready;
  end

  function automatic int push_expected(input bq_t msg);
    int n = msg.size();
    int nw = n / 4 + 1;
    for (int w = 0; w < nw; w++) begin
      logic [31:0] d = '0;
      int k = 0;
      for (int b = 0; b < 4; b++)
        if (4 * w + b < n) begin
          d[31 - 8 * b -: 8] = msg[4 * w + b];
          k++;
        end
      exp_q.push_back({(w == nw - 1), 2'(k % 4), d});
    end
    return (nw + 17) / 18;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit last);
    int n = 0;
    byte_in = b;
    byte_valid = 1'b1;
    byte_last = last;
    while (byte_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (byte_ready !== 1'b1) begin
      errors++;
      $error("FAIL byte_accept observed=%0h expected=1", byte_ready);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    byte_last = 1'b0;
  endtask

  task automatic send_msg(input bq_t msg, input bit bp, output int blocks);
    int hold_at = (msg.size() < 4) ? msg.size() - 1 : 3;
    blocks = push_expected(msg);
    if (bp) begin
      @(posedge clk);
      #1 force_full = 1'b1;
      @(negedge clk);
    end
    for (int i = 0; i < msg.size(); i++) begin
      send_byte(msg[i], i == msg.size() - 1);
      if (bp && i == hold_at) begin
        repeat (10) begin
          checks++;
          if (pad_in_ready !== 1'b1) begin
            errors++;
            $error("FAIL bp_pending observed=%0h expected=1", pad_in_ready);
          end
          checks++;
          if (pad_in !== exp_q[0][31:0]) begin
            errors++;
            $error("FAIL bp_data observed=%0h expected=%0h", pad_in, exp_q[0][31:0]);
          end
          checks++;
          if (pad_is_last !== exp_q[0][34]) begin
            errors++;
            $error("FAIL bp_last observed=%0h expected=%0h", pad_is_last, exp_q[0][34]);
          end
          checks++;
          if (pad_byte_num !== exp_q[0][33:32]) begin
            errors++;
            $error("FAIL bp_bnum observed=%0h expected=%0h", pad_byte_num, exp_q[0][33:32]);
          end
          checks++;
          if (byte_ready !== 1'b0) begin
            errors++;
            $error("FAIL bp_no_ready observed=%0h expected=0", byte_ready);
          end
          @(negedge clk);
        end
        @(posedge clk);
        #1 force_full = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  task automatic run_msg(input bq_t msg, input bit bp);
    int blocks, r0, a0, c0;
    int n = 0;
    r0 = n_round;
    a0 = n_absorb;
    send_msg(msg, bp, blocks);
    while (hash_valid !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (hash_valid !== 1'b1) begin
      errors++;
      $error("FAIL hash_valid observed=%0h expected=1", hash_valid);
    end
    checks++;
    if (n_round - r0 != 24 * blocks) begin
      errors++;
      $error("FAIL round_count observed=%0d expected=%0d", n_round - r0, 24 * blocks);
    end
    checks++;
    if (n_absorb - a0 != blocks) begin
      errors++;
      $error("FAIL absorb_count observed=%0d expected=%0d", n_absorb - a0, blocks);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL words_left observed=%0d expected=0", exp_q.size());
    end
    c0 = n_clr;
    repeat (5) begin
      checks++;
      if (hash_valid !== 1'b1) begin
        errors++;
        $error("FAIL hold_valid observed=%0h expected=1", hash_valid);
      end
      checks++;
      if (byte_ready !== 1'b0) begin
        errors++;
        $error("FAIL done_no_ready observed=%0h expected=0", byte_ready);
      end
      @(negedge clk);
    end
    hash_ack = 1'b1;
    @(negedge clk);
    hash_ack = 1'b0;
    checks++;
    if (pad_clr !== 1'b1) begin
      errors++;
      $error("FAIL clr_pulse observed=%0h expected=1", pad_clr);
    end
    checks++;
    if (hash_valid !== 1'b0) begin
      errors++;
      $error("FAIL valid_drop observed=%0h expected=0", hash_valid);
    end
    checks++;
    if (byte_ready !== 1'b1) begin
      errors++;
      $error("FAIL idle_ready observed=%0h expected=1", byte_ready);
    end
    @(negedge clk);
    checks++;
    if (pad_clr !== 1'b0) begin
      errors++;
      $error("FAIL clr_once observed=%0h expected=0", pad_clr);
    end
    checks++;
    if (n_clr - c0 != 1) begin
      errors++;
      $error("FAIL clr_count observed=%0d expected=1", n_clr - c0);
    end
  endtask

  initial begin
    bq_t m;
    int blocks, c0, len;
    int n = 0;
    reset = 1'b0;
    byte_in = 8'h00;
    byte_valid = 1'b0;
    byte_last = 1'b0;
    hash_ack = 1'b0;
    #2;
    checks++;
    if (outs !== 48'd0) begin
      errors++;
      $error("FAIL reset_outputs observed=%0h expected=0", outs);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (byte_ready !== 1'b1) begin
      errors++;
      $error("FAIL ready_after_reset observed=%0h expected=1", byte_ready);
    end

    hash_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    hash_ack = 1'b0;
    checks++;
    if (pad_clr !== 1'b0) begin
      errors++;
      $error("FAIL stray_ack_clr observed=%0h expected=0", pad_clr);
    end
    checks++;
    if (hash_valid !== 1'b0) begin
      errors++;
      $error("FAIL stray_ack_valid observed=%0h expected=0", hash_valid);
    end

    m = '{8'h61, 8'h62, 8'h63};
    run_msg(m, 1'b0);

    m = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_msg(m, 1'b1);

    m.delete();
    repeat (72) m.push_back(8'($urandom));
    run_msg(m, 1'b0);

    for (int k = 0; k < 5; k++) begin
      len = $urandom_range(1, 80);
      m.delete();
      repeat (len) m.push_back(8'($urandom));
      run_msg(m, k == 2);
    end

    m = '{8'h61, 8'h62, 8'h63};
    run_msg(m, 1'b0);

    send_msg(m, 1'b0, blocks);
    while (!(round_en === 1'b1 && round_idx === 5'd10) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (round_idx !== 5'd10) begin
      errors++;
      $error("FAIL reach_round10 observed=%0h expected=a", round_idx);
    end
    c0 = n_clr;
    #1 reset = 1'b0;
    #1;
    checks++;
    if (outs !== 48'd0) begin
      errors++;
      $error("FAIL abort_outputs observed=%0h expected=0", outs);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (hash_valid !== 1'b0) begin
        errors++;
        $error("FAIL abort_no_valid observed=%0h expected=0", hash_valid);
      end
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (n_clr - c0 != 0) begin
      errors++;
      $error("FAIL abort_no_clr observed=%0d expected=0", n_clr - c0);
    end
    checks++;
    if (byte_ready !== 1'b1) begin
      errors++;
      $error("FAIL ready_after_abort observed=%0h expected=1", byte_ready);
    end
    run_msg(m, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sha3_sequencer.md
# sha3_sequencer

Top-level controller for the SHA-3 hashing path: packs an incoming byte stream into 32-bit words for the padder, tracks the end of the message, and detects which 576-bit block is final. For each rate block the padder emits, it acknowledges the padder, strobes an absorb into the permutation state, and drives a 24-cycle round schedule. It sits between the UART receive path and the padder / Keccak-f round datapath. After the host accepts the digest, it re-arms the padder for the next message.

## Interface
- `ROUNDS`, default 24: permutation rounds per block.
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-low reset.
- `byte_in`  in  8: message byte.
- `byte_valid`  in  1: `byte_in` is valid.
- `byte_last`  in  1: qualifies `byte_valid`; this is the final byte of the message. Messages are at least 1 byte.
- `byte_ready`  out  1: byte is consumed when `byte_valid & byte_ready`.
- `pad_in`  out  32: word to the padder. First byte of the word is at [31:24].
- `pad_in_ready`  out  1: `pad_in` is valid.
- `pad_is_last`  out  1: word is the message tail.
- `pad_byte_num`  out  2: valid bytes in the tail word (0–3).
- `pad_buffer_full`  in  1: padder block buffer is full. A word is accepted when `pad_in_ready & ~pad_buffer_full`.
- `pad_out_ready`  in  1: a padded 576-bit block is available.
- `pad_f_ack`  out  1: one-cycle pulse that releases the padder block.
- `pad_clr`  out  1: one-cycle, active-high synchronous clear to the padder.
- `absorb`  out  1: XOR the padder block into the state this cycle.
- `round_en`  out  1: apply one round this cycle.
- `round_idx`  out  5: round constant index.
- `perm_busy`  out  1: in the round phase.
- `hash_valid`  out  1: the permutation state holds the final digest.
- `hash_ack`  in  1: the host has taken the digest.

## Operation
- **Packer**
  - Holds a 32-bit shift register, a 2-bit byte count, and a `word_pend` flag.
  - `byte_ready = ~word_pend & ~last_sent & (fsm != DONE)`.
  - An accepted byte shifts into the next lane, MSB-first.
  - On the 4th byte, the packer sets `word_pend` with `is_last = 0`.
  - On `byte_last` with k = 1..3 bytes collected: `word_pend` is set, `is_last = 1`, `byte_num = k`, and unused lanes are 0.
  - On `byte_last` that completes 4 bytes: the full word is sent first, then an empty tail word (`is_last = 1`, `byte_num = 0`, data 0).
  - When the `is_last` word is accepted, `last_sent` is set.
  - A `block_final` flag is set in the same cycle. It is captured per block: it means the tail word landed in the block currently filling.
- **FSM** (states `IDLE`, `WAIT_BLK`, `ABSORB`, `ROUND`, `DONE`)
  - `IDLE` → `WAIT_BLK` on the first accepted byte.
  - `WAIT_BLK` → `ABSORB` when `pad_out_ready = 1`. On this edge, the FSM latches `final_q = block_final` and clears `block_final`.
  - `ABSORB` lasts one cycle: `absorb = 1`, `pad_f_ack = 1`. Then → `ROUND` with `round_idx = 0`.
  - `ROUND` lasts `ROUNDS` cycles: `round_en = 1`, `round_idx` counts 0..23. Leaving at idx 23: → `DONE` if `final_q`, else → `WAIT_BLK`.
  - `DONE`: `hash_valid = 1`, held until `hash_ack`. Then `pad_clr` pulses for 1 cycle, `last_sent` and the packer clear, and the FSM goes → `IDLE`.
- The packer keeps feeding the padder during `ROUND`, so the next block fills while the current one is permuted.

## Timing
- **Reset values:** all outputs are 0, the FSM is in `IDLE`, and all counters and flags are cleared.
- **Reset mid-operation:** an asynchronous reset aborts immediately; no `pad_clr` is issued. The padder is reset by the system reset.
- **Block latency:** `pad_out_ready` sampled high → `absorb`/`pad_f_ack` on the next cycle → the first `round_en` one cycle later. That gives 26 cycles from block ready to the next `WAIT_BLK` or `DONE`.
- **Digest latency:** `hash_valid` rises on the cycle after `round_idx = 23`.
- **Tail backpressure:** while `pad_buffer_full = 1`, `pad_in`, `pad_in_ready`, `pad_is_last` and `pad_byte_num` are held stable.
- **Same-cycle accept and capture:** if the tail word is accepted in the same cycle that `WAIT_BLK` sees `pad_out_ready`, this cannot happen, because the padder accepts nothing while full. The tail therefore always belongs to the next captured block.
- **Ack timing:** `hash_ack` is ignored outside `DONE`. `hash_ack` in the first `DONE` cycle is honoured.
- **Round counter:** the round counter never wraps past `ROUNDS-1`.

## Structure
- **Package `sha3_pkg`:**
  - `ROUNDS`
  - `RATE_WORDS = 18`
  - the FSM state enum
  - the round-index width (5)
- **Sub-module `sha3_byte_packer`:** byte → word packing, tail generation, and the `last_sent`/`block_final` flags.
- **Top level:** the FSM and the round counter.

## Test plan
- **"abc":** bytes 0x61, 0x62, 0x63 (last) → one word `pad_in = 0x61626300`, `pad_is_last = 1`, `byte_num = 3`. Then one `absorb`, 24 `round_en` cycles with idx 0..23, and `hash_valid` on the next cycle.
- **4-byte message** 0x01020304: → a word 0x01020304 with `is_last = 0`, then a word 0x00000000 with `is_last = 1`, `byte_num = 0`. Exactly one permutation.
- **72-byte message:**
  - 18 full words; block 1 has `final_q = 0` → `WAIT_BLK` after round 23.
  - The empty tail word produces block 2 → second permutation → `hash_valid`.
  - Total of 48 `round_en` cycles.
- **Backpressure:** hold `pad_buffer_full = 1` for 10 cycles with a word pending → outputs stable, `byte_ready = 0`, no bytes lost.
- **Completion handshake:** `hash_ack` after 5 cycles in `DONE` → `pad_clr` high for exactly 1 cycle, then `IDLE`, `byte_ready = 1`. A second "abc" reproduces the same sequence.
- **Reset at `round_idx = 10`:** drive `reset` low → all outputs 0 immediately, FSM in `IDLE`, no `hash_valid`.
